// File: rtl/spi_cmd_selector_if.sv
// Bus between the channel sequencer and the MOSI command encoder.
interface spi_cmd_selector_if;
  logic [5:0]  channel;
  logic [1:0]  bias;
  logic [1:0]  gain;
  logic [15:0] MOSI_cmd;
  logic        cmd_err;

  // Sequencer side: requests a conversion and receives the encoded word.
  modport master (
    output channel,
    output bias,
    output gain,
    input  MOSI_cmd,
    input  cmd_err
  );

  // Encoder side.
  modport slave (
    input  channel,
    input  bias,
    input  gain,
    output MOSI_cmd,
    output cmd_err
  );
endinterface

// File: rtl/spi_cmd_selector.sv
// Registered encoder: channel/bias/gain -> 16-bit SPI convert command with even parity.
// Illegal requests raise cmd_err; out-of-range channels produce a NOP word.
module spi_cmd_selector #(
  parameter int unsigned NUM_CH = 16,
  parameter logic [1:0]  CMD_OP = 2'b01
) (
  input  logic                 CLK,
  input  logic                 RST,
  spi_cmd_selector_if.slave    bus
);

  localparam logic [1:0] BiasForbidden = 2'b10;
  localparam logic [1:0] BiasInternal  = 2'b01;

  logic [15:0] mosi_cmd_d, mosi_cmd_q;
  logic        cmd_err_d, cmd_err_q;
  logic [1:0]  bias_eff;
  logic        ch_oor;
  logic        bias_bad;
  logic [15:0] word_raw;

  // Decode the request: substitute forbidden bias, build word, pick NOP on bad channel.
  always_comb begin
    ch_oor     = 32'(bus.channel) >= NUM_CH;
    bias_bad   = (bus.bias == BiasForbidden);
    bias_eff   = bias_bad ? BiasInternal : bus.bias;
    word_raw   = {CMD_OP, bus.channel, bias_eff, bus.gain, 3'b000, 1'b0};
    // Parity over [15:1] makes the full word's popcount even.
    word_raw[0] = ^word_raw[15:1];
    mosi_cmd_d = word_raw;
    cmd_err_d  = bias_bad;
    if (ch_oor) begin
      mosi_cmd_d = 16'h0000;
      cmd_err_d  = 1'b1;
    end
  end

  // Output registers; synchronous reset has priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mosi_cmd_q <= 16'h0000;
      cmd_err_q  <= 1'b0;
    end else begin
      mosi_cmd_q <= mosi_cmd_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign bus.MOSI_cmd = mosi_cmd_q;
  assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_cmd_selector.sv
// Directed bench for spi_cmd_selector with hand-computed command words.
module tb_spi_cmd_selector;

  logic CLK;
  logic RST;
  int   n_vec;
  int   n_bad;

  spi_cmd_selector_if bus ();

  spi_cmd_selector #(
    .NUM_CH (16),
    .CMD_OP (2'b01)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] ch, input logic [1:0] b, input logic [1:0] g);
    bus.channel = ch;
    bus.bias    = b;
    bus.gain    = g;
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [15:0] prev;
    n_vec = 0;
    n_bad = 0;
    RST = 1'b1;
    drive(6'd42, 2'b10, 2'b01);
    step();
    step();
    check("reset_cmd", bus.MOSI_cmd, 16'h0000);
    check("reset_err", {15'd0, bus.cmd_err}, 16'd0);

    drive(6'd3, 2'b01, 2'b11);
    step();
    check("reset_hold_cmd", bus.MOSI_cmd, 16'h0000);
    check("reset_hold_err", {15'd0, bus.cmd_err}, 16'd0);

    RST = 1'b0;
    step();
    check("ch3_cmd", bus.MOSI_cmd, 16'h4370);
    check("ch3_err", {15'd0, bus.cmd_err}, 16'd0);

    drive(6'd0, 2'b00, 2'b00);
    step();
    check("ch0_cmd", bus.MOSI_cmd, 16'h4001);
    check("ch0_err", {15'd0, bus.cmd_err}, 16'd0);

    drive(6'd15, 2'b11, 2'b01);
    step();
    check("ch15_cmd", bus.MOSI_cmd, 16'h4FD0);
    check("ch15_err", {15'd0, bus.cmd_err}, 16'd0);

    // Sweep: bias=00 gain=10; output must lag input by exactly one edge.
    for (int c = 0; c < 16; c++) begin
      prev = bus.MOSI_cmd;
      drive(6'(c), 2'b00, 2'b10);
      #1;
      check("sweep_pre_edge", bus.MOSI_cmd, prev);
      step();
      check("sweep_channel", {10'd0, bus.MOSI_cmd[13:8]}, 16'(c));
      check("sweep_parity", 16'($countones(bus.MOSI_cmd) % 2), 16'd0);
      check("sweep_fields", {bus.MOSI_cmd[15:14], bus.MOSI_cmd[7:1], 7'd0},
            {2'b01, 2'b00, 2'b10, 3'b000, 7'd0});
      check("sweep_err", {15'd0, bus.cmd_err}, 16'd0);
    end

    drive(6'd3, 2'b10, 2'b11);
    step();
    check("forbid_cmd", bus.MOSI_cmd, 16'h4370);
    check("forbid_err", {15'd0, bus.cmd_err}, 16'd1);

    drive(6'd3, 2'b01, 2'b11);
    step();
    check("forbid_clr_cmd", bus.MOSI_cmd, 16'h4370);
    check("forbid_clr_err", {15'd0, bus.cmd_err}, 16'd0);

    // ch5 bias=10 gain=00: 01 000101 01 00 000 -> 0x4540, popcount 4 -> parity 0.
    drive(6'd5, 2'b10, 2'b00);
    step();
    check("forbid5_cmd", bus.MOSI_cmd, 16'h4540);
    check("forbid5_err", {15'd0, bus.cmd_err}, 16'd1);

    drive(6'd16, 2'b01, 2'b11);
    step();
    check("oor16_cmd", bus.MOSI_cmd, 16'h0000);
    check("oor16_err", {15'd0, bus.cmd_err}, 16'd1);

    drive(6'd63, 2'b10, 2'b01);
    step();
    check("oor63_cmd", bus.MOSI_cmd, 16'h0000);
    check("oor63_err", {15'd0, bus.cmd_err}, 16'd1);

    drive(6'd15, 2'b11, 2'b01);
    step();
    check("ch15_again_cmd", bus.MOSI_cmd, 16'h4FD0);
    check("ch15_again_err", {15'd0, bus.cmd_err}, 16'd0);

    drive(6'd3, 2'b01, 2'b11);
    step();
    check("pre_rst_cmd", bus.MOSI_cmd, 16'h4370);
    RST = 1'b1;
    step();
    check("mid_rst_cmd", bus.MOSI_cmd, 16'h0000);
    check("mid_rst_err", {15'd0, bus.cmd_err}, 16'd0);
    RST = 1'b0;
    step();
    check("post_rst_cmd", bus.MOSI_cmd, 16'h4370);
    check("post_rst_err", {15'd0, bus.cmd_err}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
